// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: decoded ops, bridge FSM states, bus size codes.
package dmem_bridge_pkg;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_SB,
    OP_SH,
    OP_SW
  } decoded_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } dmem_state_t;

  typedef enum logic [1:0] {
    DSIZE_BYTE = 2'd0,
    DSIZE_HALF = 2'd1,
    DSIZE_WORD = 2'd2
  } dsize_t;

  // Bus size from the lane-enable mask; anything wider than a half is a word.
  function automatic logic [1:0] size_from_mask(input logic [3:0] mask);
    dsize_t s;
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: s = DSIZE_BYTE;
      4'b0011, 4'b1100:                   s = DSIZE_HALF;
      default:                            s = DSIZE_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_bridge_load_align.sv
// Combinational load alignment: picks the byte/half addressed by addr and extends it per op.
module load_align
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        addr,
  input  decoded_op_t       op,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] rd
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'd0:    lane_b = raw[7:0];
      2'd1:    lane_b = raw[15:8];
      2'd2:    lane_b = raw[23:16];
      default: lane_b = raw[31:24];
    endcase
    lane_h = addr[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    rd = '0;
    case (op)
      OP_LB:   rd = {{(DATA_W-8){lane_b[7]}}, lane_b};
      OP_LBU:  rd = {{(DATA_W-8){1'b0}}, lane_b};
      OP_LH:   rd = {{(DATA_W-16){lane_h[15]}}, lane_h};
      OP_LHU:  rd = {{(DATA_W-16){1'b0}}, lane_h};
      OP_LW:   rd = raw;
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage to sram-like data bus bridge; one access outstanding, pipeline stalled while busy.
// Optional bus error reporting via `define DMEM_BUSERR_EN (adds d_err input and bus_err output).
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req_ren,
  input  logic [3:0]        req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wd,
  input  decoded_op_t       req_op,
  input  logic              flush,
  input  logic              stall_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic              d_req,
  output logic              d_wr,
  output logic [1:0]        d_size,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_wdata,
  input  logic              d_addr_ok,
  input  logic              d_data_ok,
  input  logic [DATA_W-1:0] d_rdata
`ifdef DMEM_BUSERR_EN
  ,
  input  logic              d_err,
  output logic              bus_err
`endif
);

  dmem_state_t       state, state_next;
  logic              cancel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  decoded_op_t       op_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] aligned;
  logic              access;
  logic              accept;
  logic              done;
  logic              cancel_now;

  assign access     = (|req_ren) | (|req_wen);
  assign accept     = (state == IDLE) && access && !flush;
  assign done       = ((state == REQ) && d_addr_ok && d_data_ok) ||
                      ((state == WAIT) && d_data_ok);
  // A flush landing in the completing cycle cancels just like an earlier one.
  assign cancel_now = cancel || flush;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .addr (addr_q[1:0]),
    .op   (op_q),
    .raw  (d_rdata),
    .rd   (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (d_addr_ok) begin
          if (!d_data_ok)     state_next = WAIT;
          else if (cancel_now) state_next = IDLE;
          else                state_next = HOLD;
        end
      end
      WAIT: if (d_data_ok) state_next = cancel_now ? IDLE : HOLD;
      HOLD: if (flush || !stall_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_out = 1'b0;
    rd_valid  = 1'b0;
    d_req     = 1'b0;
    case (state)
      IDLE: stall_out = accept;
      REQ: begin
        stall_out = 1'b1;
        d_req     = 1'b1;
      end
      WAIT: stall_out = 1'b1;
      HOLD: rd_valid = !flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cancel <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      op_q   <= OP_NOP;
      size_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        wd_q   <= req_wd;
        op_q   <= req_op;
        size_q <= size_from_mask(req_ren | req_wen);
        wr_q   <= |req_wen;
        cancel <= 1'b0;
      end else if ((state == REQ) || (state == WAIT)) begin
        if (done)       cancel <= 1'b0;
        else if (flush) cancel <= 1'b1;
      end
      if (done && !cancel_now) rd_q <= aligned;
    end
  end

  assign rd      = rd_q;
  assign d_wr    = wr_q;
  assign d_size  = size_q;
  assign d_addr  = addr_q;
  assign d_wdata = wd_q;

`ifdef DMEM_BUSERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (done)   err_q <= d_err;
  end

  assign bus_err = rd_valid && err_q;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: expected load results queued at issue, compared in HOLD.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_ren, req_wen;
  logic [31:0] req_addr, req_wd;
  decoded_op_t req_op;
  logic        flush, stall_in;
  logic        stall_out;
  logic [31:0] rd;
  logic        rd_valid;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
`ifdef DMEM_BUSERR_EN
  logic        bus_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wd    (req_wd),
    .req_op    (req_op),
    .flush     (flush),
    .stall_in  (stall_in),
    .stall_out (stall_out),
    .rd        (rd),
    .rd_valid  (rd_valid),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_rdata   (d_rdata)
`ifdef DMEM_BUSERR_EN
    ,
    .d_err     (1'b0),
    .bus_err   (bus_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_req;
    req_ren = '0;
    req_wen = '0;
    req_op  = OP_NOP;
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] mask);
    case ($countones(mask))
      1:       return 2'd0;
      2:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // One complete access: addr_lat extra REQ cycles before addr_ok, data_lat cycles
  // from address accept to data_ok, hold_stall cycles of stall_in while in HOLD.
  task automatic run_access(input string name, input logic [3:0] ren, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wd, input decoded_op_t op,
                            input logic [31:0] raw, input int addr_lat, input int data_lat,
                            input int hold_stall, input logic [31:0] exp_rd);
    int stalls;
    logic [31:0] want;
    stalls = 0;
    tick;
    req_ren = ren; req_wen = wen; req_addr = addr; req_wd = wd; req_op = op;
    sb_q.push_back(exp_rd);
    @(negedge clk);
    check({name, "_idle_stall"}, {31'd0, stall_out}, 32'd1);
    check({name, "_idle_dreq"}, {31'd0, d_req}, 32'd0);
    stalls += int'(stall_out);
    tick;
    for (int i = 0; i <= addr_lat; i++) begin
      d_addr_ok = (i == addr_lat);
      d_data_ok = (i == addr_lat) && (data_lat == 0);
      d_rdata   = d_data_ok ? raw : ~raw;
      @(negedge clk);
      check({name, "_dreq"}, {31'd0, d_req}, 32'd1);
      check({name, "_daddr"}, d_addr, addr);
      stalls += int'(stall_out);
      if (i == addr_lat) begin
        check({name, "_dwr"}, {31'd0, d_wr}, {31'd0, |wen});
        check({name, "_dsize"}, {30'd0, d_size}, {30'd0, exp_size(ren | wen)});
        if (|wen) check({name, "_dwdata"}, d_wdata, wd);
      end
      tick;
    end
    d_addr_ok = 1'b0; d_data_ok = 1'b0;
    for (int j = 1; j <= data_lat; j++) begin
      d_data_ok = (j == data_lat);
      d_rdata   = d_data_ok ? raw : ~raw;
      @(negedge clk);
      check({name, "_wait_dreq"}, {31'd0, d_req}, 32'd0);
      stalls += int'(stall_out);
      tick;
    end
    d_data_ok = 1'b0;
    d_rdata   = 32'hDEAD_BEEF;
    want = 32'hxxxx_xxxx;
    for (int k = 0; k <= hold_stall; k++) begin
      stall_in = (k < hold_stall);
      @(negedge clk);
      check({name, "_hold_valid"}, {31'd0, rd_valid}, 32'd1);
      check({name, "_hold_stall"}, {31'd0, stall_out}, 32'd0);
      if (k == 0) begin
        if (sb_q.size() == 0) check({name, "_sb_empty"}, 32'd1, 32'd0);
        else want = sb_q.pop_front();
      end else begin
        check({name, "_hold_dreq"}, {31'd0, d_req}, 32'd0);
      end
      check({name, "_rd"}, rd, want);
      tick;
    end
    stall_in = 1'b0;
    drop_req;
    @(negedge clk);
    check({name, "_back_idle"}, {31'd0, rd_valid}, 32'd0);
    check({name, "_stall_cycles"}, stalls, 1 + (addr_lat + 1) + data_lat);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    drop_req; req_addr = '0; req_wd = '0;
    d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = '0;
    repeat (3) tick;
    @(negedge clk);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_dreq", {31'd0, d_req}, 32'd0);
    check("rst_rd", rd, 32'd0);
    check("rst_daddr", d_addr, 32'd0);
    tick;
    reset = 1'b0;

    run_access("lw", 4'b1111, 4'b0000, 32'h8000_0010, 32'h0, OP_LW, 32'h1234_5678, 0, 0, 0, 32'h1234_5678);
    run_access("lb", 4'b1000, 4'b0000, 32'h8000_0003, 32'h0, OP_LB, 32'h80FF_FFFF, 1, 1, 0, 32'hFFFF_FF80);
    run_access("lbu", 4'b1000, 4'b0000, 32'h8000_0003, 32'h0, OP_LBU, 32'h80FF_FFFF, 0, 2, 0, 32'h0000_0080);
    run_access("sh", 4'b0000, 4'b1100, 32'h8000_0002, 32'hABCD_0000, OP_SH, 32'h7777_7777, 2, 0, 0, 32'h0);
    run_access("lh", 4'b1100, 4'b0000, 32'h8000_0002, 32'h0, OP_LH, 32'h8001_1234, 0, 0, 3, 32'hFFFF_8001);
    run_access("lhu", 4'b1100, 4'b0000, 32'h8000_0006, 32'h0, OP_LHU, 32'h8001_1234, 0, 1, 0, 32'h0000_8001);
    run_access("lb0", 4'b0001, 4'b0000, 32'h8000_0100, 32'h0, OP_LB, 32'h0000_007F, 0, 0, 0, 32'h0000_007F);
    run_access("sw", 4'b0000, 4'b1111, 32'h8000_0020, 32'h0BAD_CAFE, OP_SW, 32'h1111_1111, 1, 0, 0, 32'h0);

    // Cancelled load: flush in REQ, data two cycles later, no HOLD.
    tick;
    req_ren = 4'b1111; req_addr = 32'h8000_0030; req_op = OP_LW;
    @(negedge clk);
    check("cxl_idle_stall", {31'd0, stall_out}, 32'd1);
    tick;
    flush = 1'b1; d_addr_ok = 1'b1;
    @(negedge clk);
    check("cxl_req_dreq", {31'd0, d_req}, 32'd1);
    tick;
    flush = 1'b0; d_addr_ok = 1'b0; drop_req;
    @(negedge clk);
    check("cxl_wait1_stall", {31'd0, stall_out}, 32'd1);
    check("cxl_wait1_valid", {31'd0, rd_valid}, 32'd0);
    tick;
    d_data_ok = 1'b1; d_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    check("cxl_wait2_stall", {31'd0, stall_out}, 32'd1);
    check("cxl_wait2_valid", {31'd0, rd_valid}, 32'd0);
    tick;
    d_data_ok = 1'b0;
    @(negedge clk);
    check("cxl_after_stall", {31'd0, stall_out}, 32'd0);
    check("cxl_after_valid", {31'd0, rd_valid}, 32'd0);
    check("cxl_rd_kept", rd, 32'h0);

    // Flush during HOLD suppresses rd_valid and leaves HOLD despite stall_in.
    tick;
    req_ren = 4'b1111; req_addr = 32'h8000_0040; req_op = OP_LW;
    tick;
    d_addr_ok = 1'b1; d_data_ok = 1'b1; d_rdata = 32'hCAFE_F00D;
    tick;
    d_addr_ok = 1'b0; d_data_ok = 1'b0;
    flush = 1'b1; stall_in = 1'b1;
    @(negedge clk);
    check("hflush_valid", {31'd0, rd_valid}, 32'd0);
    tick;
    flush = 1'b0; stall_in = 1'b0; drop_req;
    @(negedge clk);
    check("hflush_idle_valid", {31'd0, rd_valid}, 32'd0);
    check("hflush_idle_stall", {31'd0, stall_out}, 32'd0);
    check("hflush_rd", rd, 32'hCAFE_F00D);

    // Reset while a store waits for data.
    tick;
    req_wen = 4'b1111; req_addr = 32'h8000_0050; req_wd = 32'h5555_AAAA; req_op = OP_SW;
    tick;
    d_addr_ok = 1'b1;
    tick;
    d_addr_ok = 1'b0; drop_req;
    @(negedge clk);
    check("rstw_in_wait", {31'd0, stall_out}, 32'd1);
    tick;
    reset = 1'b1;
    tick;
    @(negedge clk);
    check("rstw_stall", {31'd0, stall_out}, 32'd0);
    check("rstw_valid", {31'd0, rd_valid}, 32'd0);
    check("rstw_rd", rd, 32'd0);
    check("rstw_dreq", {31'd0, d_req}, 32'd0);
    check("rstw_dwr", {31'd0, d_wr}, 32'd0);
    check("rstw_dsize", {30'd0, d_size}, 32'd0);
    check("rstw_daddr", d_addr, 32'd0);
    check("rstw_dwdata", d_wdata, 32'd0);
    tick;
    reset = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    check("post_rst_idle", {31'd0, d_req}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
